// File: rtl/pe_ld_unit_response_flow_control.sv
// pe_ld_unit_response_flow_control
//   Load-unit end of the PE operand handshake. Load requests are turned into
//   reads of the PE local data memory (fixed READ_LATENCY). Returned words are
//   buffered in an in-order response FIFO and presented to the func-unit side
//   as memory_unit_rdy/ld_data. A credit scheme (FIFO entries + reads in
//   flight <= DEPTH) guarantees a slot for every return.
//
// Ports
//   clk, rst           clock (posedge), asynchronous active-low reset
//   ld_req_vld/addr    load request; accepted when ld_req_vld & ld_req_rdy
//   ld_req_rdy         credit available and no flush
//   flush              synchronous abort of in-flight and buffered data
//   rd_en/rd_addr      memory read strobe and address (combinational)
//   rd_data            memory data, valid READ_LATENCY cycles after rd_en
//   func_unit_rdy      func side ready; transfer when both rdy signals high
//   memory_unit_rdy    operand valid toward the func unit
//   ld_data            operand data, held until popped
//   occupancy          FIFO entries plus reads in flight
//
// Configuration
//   PE_LD_UNIT_BYPASS_EN : a return into an empty FIFO is presented in the
//   same cycle straight from rd_data; if popped then, it is never written.

module pe_ld_unit_response_flow_control #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_req_vld,
    input  logic [ADDR_W-1:0]            ld_req_addr,
    output logic                         ld_req_rdy,
    input  logic                         flush,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [DATA_W-1:0]            rd_data,
    input  logic                         func_unit_rdy,
    output logic                         memory_unit_rdy,
    output logic [DATA_W-1:0]            ld_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RL    = READ_LATENCY;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [RL-1:0]     vld_pipe_q, vld_pipe_d;

    logic              fifo_nonempty;
    logic [CNT_W:0]    occ_sum;
    logic              issue;
    logic              ret;
    logic              push;
    logic              pop;
    logic              pop_fifo;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        fifo_nonempty = (count_q != '0);
        occ_sum       = {1'b0, count_q} + {1'b0, inflight_q};
        occupancy     = occ_sum[CNT_W-1:0];
        // rst gates the credit so no read can be issued while held in reset
        ld_req_rdy    = rst & ~flush & (occ_sum < (CNT_W+1)'(DEPTH));
        issue         = ld_req_vld & ld_req_rdy;
        rd_en         = issue;
        rd_addr       = ld_req_addr;
        // a return landing in a flush cycle is dropped
        ret           = vld_pipe_q[RL-1] & ~flush;
`ifdef PE_LD_UNIT_BYPASS_EN
        memory_unit_rdy = fifo_nonempty | ret;
        ld_data         = (~fifo_nonempty & ret) ? rd_data : mem_q[rd_ptr_q];
        pop             = func_unit_rdy & memory_unit_rdy & ~flush;
        pop_fifo        = pop & fifo_nonempty;
        // a bypassed word consumed in its return cycle never enters the FIFO
        push            = ret & ~(pop & ~fifo_nonempty);
`else
        memory_unit_rdy = fifo_nonempty;
        ld_data         = mem_q[rd_ptr_q];
        pop             = func_unit_rdy & fifo_nonempty & ~flush;
        pop_fifo        = pop;
        push            = ret;
`endif
    end

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = issue;
        for (int unsigned i = 1; i < RL; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(vld_pipe_q[RL-1]);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop_fifo ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = rd_data;
        end
        if (flush) begin
            vld_pipe_d = '0;
            inflight_d = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            vld_pipe_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

`ifndef SYNTHESIS
    logic              chk_hold_q;
    logic [DATA_W-1:0] chk_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_hold_q <= 1'b0;
            chk_data_q <= '0;
        end else begin
            chk_hold_q <= memory_unit_rdy & ~func_unit_rdy & ~flush;
            chk_data_q <= ld_data;
            assert (!(push && !pop_fifo && count_q == CNT_W'(DEPTH)))
                else $error("push into full response FIFO");
            assert (!(pop_fifo && count_q == '0))
                else $error("pop from empty response FIFO");
            assert (inflight_q <= CNT_W'(RL))
                else $error("more reads in flight than READ_LATENCY");
            if (chk_hold_q) begin
                assert (memory_unit_rdy && ld_data == chk_data_q)
                    else $error("operand changed while waiting for func unit");
            end
        end
    end
`endif

endmodule
